// File: rtl/noise_detector.sv
// SPI-master sampler for the receive-path ADC that qualifies samples against a
// hysteretic threshold and emits one noise_valid pulse per qualified event.
module noise_detector #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 12,
  parameter int THRESHOLD   = 512,
  parameter int HYST        = 16,
  parameter int HIT_COUNT   = 3,
  parameter int SAMPLE_GAP  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   adc_miso,
  output logic                   adc_sclk,
  output logic                   adc_cs_n,
  output logic                   noise_valid,
  output logic [SAMPLE_BITS-1:0] sample,
  output logic                   sample_strobe,
  output logic [2:0]             debug_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    EVAL     = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam int TMAX  = (CLK_DIV > SAMPLE_GAP) ? CLK_DIV : SAMPLE_GAP;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int EDGES = 2 * SAMPLE_BITS;
  localparam int EW    = $clog2(EDGES + 1);
  localparam int CW    = $clog2(HIT_COUNT + 1);
  localparam int REARM = THRESHOLD - HYST;

  localparam logic [TW-1:0] DIV_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(SAMPLE_GAP - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(EDGES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(HIT_COUNT);

  state_t                 state;
  logic [TW-1:0]          timer;
  logic [EW-1:0]          edge_cnt;
  logic [SAMPLE_BITS-1:0] shreg;
  logic [CW-1:0]          hit_cnt;
  logic                   armed;

  int                     sval;
  logic                   hit;
  logic                   rearm;
  logic                   fire;
  logic [CW-1:0]          cnt_next;

  assign debug_state = state;

  // REARM may be negative, so the comparison is done in signed int space.
  always_comb begin
    sval     = int'(shreg);
    hit      = (sval > THRESHOLD);
    rearm    = !hit && (sval < REARM);
    cnt_next = '0;
    if (hit) begin
      cnt_next = (hit_cnt == CNT_MAX) ? CNT_MAX : hit_cnt + CW'(1);
    end
    fire = armed && hit && (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      edge_cnt      <= '0;
      shreg         <= '0;
      hit_cnt       <= '0;
      armed         <= 1'b1;
      adc_cs_n      <= 1'b1;
      adc_sclk      <= 1'b0;
      noise_valid   <= 1'b0;
      sample_strobe <= 1'b0;
      sample        <= '0;
    end else begin
      noise_valid   <= 1'b0;
      sample_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
          timer    <= '0;
          if (enable) begin
            adc_cs_n <= 1'b0;
            state    <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (timer == DIV_LAST) begin
            timer    <= '0;
            edge_cnt <= '0;
            state    <= SHIFT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SHIFT: begin
          // Each of the EDGES half-periods ends with an sclk edge; MISO is
          // captured on the clk edge that raises sclk.
          if (timer == DIV_LAST) begin
            timer    <= '0;
            edge_cnt <= edge_cnt + EW'(1);
            if (!adc_sclk) begin
              adc_sclk <= 1'b1;
              shreg    <= {shreg[SAMPLE_BITS-2:0], adc_miso};
            end else begin
              adc_sclk <= 1'b0;
            end
            if (edge_cnt == EDGE_LAST) begin
              adc_sclk <= 1'b0;
              state    <= CS_HOLD;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CS_HOLD: begin
          adc_sclk <= 1'b0;
          if (timer == DIV_LAST) begin
            timer    <= '0;
            adc_cs_n <= 1'b1;
            state    <= EVAL;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        EVAL: begin
          sample        <= shreg;
          sample_strobe <= 1'b1;
          noise_valid   <= fire;
          hit_cnt       <= cnt_next;
          if (fire) begin
            armed <= 1'b0;
          end else if (rearm) begin
            armed <= 1'b1;
          end
          timer <= '0;
          state <= GAP;
        end
        GAP: begin
          adc_cs_n <= 1'b1;
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (enable) begin
              adc_cs_n <= 1'b0;
              state    <= CS_SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
          timer    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noise_detector.sv
// Bench for noise_detector: serial ADC model feeding queued words, and a
// history-based reference for when noise_valid must fire.
module tb_noise_detector;
  localparam int SB     = 12;
  localparam int THR    = 512;
  localparam int HY     = 16;
  localparam int HC     = 3;
  localparam int DIV    = 4;
  localparam int GAPN   = 16;
  localparam int PERIOD = 121;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          adc_miso = 1'b0;
  logic          adc_sclk, adc_cs_n, noise_valid, sample_strobe;
  logic [SB-1:0] sample;
  logic [2:0]    debug_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_strobe = -1;

  noise_detector #(
    .CLK_DIV(DIV), .SAMPLE_BITS(SB), .THRESHOLD(THR),
    .HYST(HY), .HIT_COUNT(HC), .SAMPLE_GAP(GAPN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_miso(adc_miso),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .noise_valid(noise_valid),
    .sample(sample), .sample_strobe(sample_strobe), .debug_state(debug_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ADC: MSB presented when CS falls, next bit after each SCLK falling edge.
  int            word_q[$];
  logic [SB-1:0] sent_q[$];
  logic [SB-1:0] adc_word = '0;
  int            bit_idx = 0;
  int            rises_conv = 0;
  int            rise_t[$];

  always @(negedge adc_cs_n) begin
    if (word_q.size() > 0) adc_word = SB'(word_q.pop_front());
    else adc_word = SB'($urandom);
    sent_q.push_back(adc_word);
    bit_idx    = SB - 1;
    adc_miso   = adc_word[bit_idx];
    rises_conv = 0;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && bit_idx > 0) begin
      bit_idx  = bit_idx - 1;
      adc_miso = adc_word[bit_idx];
    end
  end

  always @(posedge adc_sclk) begin
    rise_t.push_back(cyc);
    rises_conv = rises_conv + 1;
  end

  // Reference: fire when the trailing run of hits is exactly HC long and a
  // re-arm sample has been seen since the previous pulse (or none yet).
  int hist[$];
  int last_pulse = -1;

  function automatic bit model_push(input int v);
    int run;
    bit arm;
    hist.push_back(v);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] > THR) run++;
      else break;
    end
    arm = (last_pulse < 0);
    for (int i = last_pulse + 1; i < hist.size(); i++)
      if (hist[i] < THR - HY) arm = 1'b1;
    if (run == HC && arm) begin
      last_pulse = hist.size() - 1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_conv(input string tag, input bit chk_period);
    int n;
    bit got;
    logic [SB-1:0] exp_s;
    bit exp_nv;
    n = 0;
    got = 1'b0;
    while (!got && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
      if (sample_strobe === 1'b1) got = 1'b1;
      else if (noise_valid !== 1'b0) check({tag, "_stray_nv"}, 32'(noise_valid), 32'd0);
    end
    if (!got) begin
      check({tag, "_strobe_timeout"}, 32'(sample_strobe), 32'd1);
      return;
    end
    exp_s  = (sent_q.size() > 0) ? sent_q.pop_front() : '0;
    exp_nv = model_push(int'(exp_s));
    check({tag, "_sample"}, 32'(sample), 32'(exp_s));
    check({tag, "_nv"}, 32'(noise_valid), 32'(exp_nv));
    if (chk_period && last_strobe >= 0)
      check({tag, "_period"}, 32'(cyc - last_strobe), 32'(PERIOD));
    last_strobe = cyc;
    @(negedge clk);
    check({tag, "_strobe_width"}, 32'(sample_strobe), 32'd0);
    check({tag, "_nv_width"}, 32'(noise_valid), 32'd0);
    check({tag, "_hold"}, 32'(sample), 32'(exp_s));
  endtask

  task automatic wait_cs_low(input string tag);
    int n;
    n = 0;
    while (adc_cs_n !== 1'b0 && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cs_low"}, 32'(adc_cs_n), 32'd0);
  endtask

  task automatic wait_rises(input string tag, input int k);
    int n;
    n = 0;
    while (rises_conv < k && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rises"}, 32'(rises_conv), 32'(k));
  endtask

  initial begin
    int fall_cyc;
    int nconv;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int fall_cyc;
    int nconv;

    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd0);
    check("rst_nv", 32'(noise_valid), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_state", 32'(debug_state), 32'd0);

    @(negedge clk) reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check("idle", 32'({adc_cs_n, adc_sclk, noise_valid, sample_strobe, debug_state}), 32'b1000000);
    end

    word_q = {'hA5C, 'hA5C, 100,
              600, 600, 600, 600, 100, 600, 600, 600,
              100, 600, 600, 600, 500, 600, 600, 600,
              512, 512, 512, 512, 0, 4095, 4095, 4095};
    for (int i = 0; i < 16; i++)
      word_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                                   : int'($urandom_range(480, 560)));
    nconv = word_q.size();

    rise_t.delete();
    @(negedge clk) enable = 1'b1;
    check("cs_before_edge", 32'(adc_cs_n), 32'd1);
    @(posedge clk);
    #1;
    fall_cyc = cyc;
    check("cs_fall", 32'(adc_cs_n), 32'd0);
    check("state_setup", 32'(debug_state), 32'd1);
    expect_conv("conv0", 1'b0);
    check("rise_count", 32'(rise_t.size()), 32'd12);
    check("first_rise", 32'(rise_t[0] - fall_cyc), 32'(2 * DIV));
    for (int i = 1; i < rise_t.size(); i++)
      check("rise_spacing", 32'(rise_t[i] - rise_t[i-1]), 32'(2 * DIV));

    for (int k = 1; k < nconv; k++) expect_conv("conv", 1'b1);

    // Drop enable while bit 5 is shifting; that conversion must still finish.
    word_q.push_back(600);
    wait_cs_low("drop");
    wait_rises("drop", 5);
    @(negedge clk) enable = 1'b0;
    expect_conv("drop", 1'b1);
    repeat (GAPN - 2) @(negedge clk);
    check("drop_gap", 32'(debug_state), 32'd5);
    @(negedge clk);
    check("drop_idle", 32'(debug_state), 32'd0);
    repeat (150) begin
      @(negedge clk);
      check("drop_quiet", 32'({adc_cs_n, adc_sclk, sample_strobe, debug_state}), 32'b100000);
    end

    // Reset in the middle of SHIFT aborts without publishing.
    word_q.delete();
    word_q = {700, 600, 600, 600};
    @(negedge clk) enable = 1'b1;
    wait_cs_low("abort");
    wait_rises("abort", 3);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs_n", 32'(adc_cs_n), 32'd1);
    check("abort_sclk", 32'(adc_sclk), 32'd0);
    check("abort_state", 32'(debug_state), 32'd0);
    check("abort_sample", 32'(sample), 32'd0);
    check("abort_strobe", 32'(sample_strobe), 32'd0);
    sent_q.delete();
    hist.delete();
    last_pulse = -1;
    @(negedge clk) reset = 1'b1;
    check("abort_sample_hold", 32'(sample), 32'd0);
    expect_conv("post_rst", 1'b0);
    expect_conv("post_rst", 1'b1);
    expect_conv("post_rst", 1'b1);
    check("post_rst_third_pulse", 32'(last_pulse), 32'd2);
    @(negedge clk) enable = 1'b0;
    repeat (2 * PERIOD) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
